// File: rtl/s2p_sched_if.sv
// Bus between the round-robin s2p scheduler, its serial requesters and the shared s2p.
// master = scheduler side, slave = requesters plus the s2p instance.
interface s2p_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_len;
  logic [NREQ-1:0]   sdi;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [15:0]       rdata;
  logic              err;
  logic              s2p_enable;
  logic [3:0]        s2p_len;
  logic              s2p_data_in;
  logic [15:0]       s2p_data_out;
  logic              s2p_ready;

  modport master (
    input  req, req_len, sdi, s2p_data_out, s2p_ready,
    output grant, done, rdata, err, s2p_enable, s2p_len, s2p_data_in
  );

  modport slave (
    output req, req_len, sdi, s2p_data_out, s2p_ready,
    input  grant, done, rdata, err, s2p_enable, s2p_len, s2p_data_in
  );
endinterface

// File: rtl/s2p_sched.sv
// Round-robin scheduler sharing one s2p deserializer among NREQ serial requesters.
// state    | meaning
// ST_IDLE  | no transfer; pick next requester from rr pointer
// ST_SHIFT | grant and s2p enable held; wait for s2p ready or timeout
// ST_GAP   | one cycle with enable low so the s2p clears before the next grant
module s2p_sched #(
  parameter int NREQ     = 4,
  parameter int TO_SLACK = 2
) (
  input  logic        clk,
  input  logic        reset,
  s2p_sched_if.master bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(16 + TO_SLACK + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_grant, w_grant_nxt;
  logic [NREQ-1:0]  r_done, w_done_nxt;
  logic [15:0]      r_rdata, w_rdata_nxt;
  logic             r_err, w_err_nxt;
  logic             r_en, w_en_nxt;
  logic [3:0]       r_len, w_len_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;

  logic             w_any;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W-1:0] w_cand;
  logic [4:0]       w_word_len;
  logic [CNT_W-1:0] w_tmo;

  // First requester at or after the rr pointer, wrapping upward.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = PTR_W'((int'(r_ptr) + i) % NREQ);
      if (!w_any && bus.req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  assign w_word_len = (r_len == 4'd0) ? 5'd16 : {1'b0, r_len};
  assign w_tmo      = CNT_W'(w_word_len) + CNT_W'(TO_SLACK) - CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = 1'b0;
    w_en_nxt    = r_en;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_en_nxt            = 1'b1;
          w_len_nxt           = bus.req_len[{w_pick, 2'b00} +: 4];
          w_cnt_nxt           = '0;
          w_ptr_nxt           = (int'(w_pick) == NREQ - 1) ? '0 : w_pick + PTR_W'(1);
          w_state_nxt         = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (bus.s2p_ready) begin
          w_rdata_nxt = bus.s2p_data_out;
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_en_nxt    = 1'b0;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == w_tmo) begin
          w_rdata_nxt = '0;
          w_done_nxt  = r_grant;
          w_err_nxt   = 1'b1;
          w_grant_nxt = '0;
          w_en_nxt    = 1'b0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_en    <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      r_en    <= w_en_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.done        = r_done;
  assign bus.rdata       = r_rdata;
  assign bus.err         = r_err;
  assign bus.s2p_enable  = r_en;
  assign bus.s2p_len     = r_len;
  // Only the granted line reaches the s2p; zero while idle since grant is zero.
  assign bus.s2p_data_in = |(bus.sdi & r_grant);
endmodule

// File: tb/tb_s2p_sched.sv
// Bench for s2p_sched: behavioural requesters and s2p stand-in, round-robin reference model.
module tb_s2p_sched;
  localparam int NREQ     = 4;
  localparam int TO_SLACK = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_pass   = 0;
  int   n_checks = 0;
  int   cyc      = 0;
  int   en_cnt   = 0;
  int   m_ptr    = 0;
  int   g_cyc, d_cyc, en_base;

  s2p_sched_if #(.NREQ(NREQ)) bus ();
  s2p_sched #(.NREQ(NREQ), .TO_SLACK(TO_SLACK)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.s2p_enable === 1'b1) en_cnt <= en_cnt + 1;

  // Requesters: present MSB first, advance one bit per posedge while granted.
  logic [15:0] tb_word [NREQ];
  int          tb_len  [NREQ];
  int          pos     [NREQ];

  function automatic logic bit_at(input logic [15:0] w, input int len, input int p);
    int b;
    b = ((len == 0) ? 16 : len) - 1 - p;
    if (b < 0 || b > 15) return 1'b0;
    return w[b[3:0]];
  endfunction

  always @(posedge clk)
    for (int i = 0; i < NREQ; i++) pos[i] <= (bus.grant[i] === 1'b1) ? pos[i] + 1 : 0;

  always_comb
    for (int i = 0; i < NREQ; i++) bus.sdi[i] = bit_at(tb_word[i], tb_len[i], pos[i]);

  // s2p stand-in: samples on negedge while enabled, ready after len samples.
  int          s2p_cnt;
  logic [15:0] s2p_q;
  logic        s2p_rdy;
  bit          stub_low = 1'b0;
  int          s2p_l;
  assign s2p_l            = (bus.s2p_len == 4'd0) ? 16 : int'(bus.s2p_len);
  assign bus.s2p_data_out = s2p_q;
  assign bus.s2p_ready    = s2p_rdy;

  always @(negedge clk or posedge reset) begin
    if (reset || bus.s2p_enable !== 1'b1) begin
      s2p_cnt <= 0;
      s2p_q   <= '0;
      s2p_rdy <= 1'b0;
    end else if (s2p_cnt < s2p_l) begin
      s2p_q   <= {s2p_q[14:0], bus.s2p_data_in};
      s2p_cnt <= s2p_cnt + 1;
      if (s2p_cnt + 1 == s2p_l) s2p_rdy <= !stub_low;
    end
  end

  // Reference model helpers.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] w, input int len);
    int l;
    logic [16:0] m;
    l = (len == 0) ? 16 : len;
    m = (17'd1 << l) - 17'd1;
    return w & m[15:0];
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r, n;
    r = -1;
    n = 0;
    for (int i = 0; i < NREQ; i++) if (v[i] === 1'b1) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int idx, output bit to);
    int n;
    to = 1'b1; idx = -1; n = 0;
    while (n < 60) begin
      tick(); n++;
      if (bus.grant !== '0) begin
        idx = oh_idx(bus.grant); to = 1'b0; g_cyc = cyc; en_base = en_cnt;
        break;
      end
    end
  endtask

  task automatic wait_done(output int idx, output logic [15:0] d, output logic e, output bit to);
    int n;
    to = 1'b1; idx = -1; d = 'x; e = 1'bx; n = 0;
    while (n < 60) begin
      tick(); n++;
      if (bus.done !== '0) begin
        idx = oh_idx(bus.done); d = bus.rdata; e = bus.err; to = 1'b0; d_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_len = '0;
    for (int i = 0; i < NREQ; i++) begin tb_word[i] = '0; tb_len[i] = 1; end
    #2 reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.grant !== '0) $display("FAIL rst_grant: got %b want 0", bus.grant); else n_pass++;
    n_checks++; if (bus.done !== '0) $display("FAIL rst_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.rdata !== 16'h0) $display("FAIL rst_rdata: got %h want 0", bus.rdata); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.err); else n_pass++;
    n_checks++; if (bus.s2p_enable !== 1'b0) $display("FAIL rst_en: got %b want 0", bus.s2p_enable); else n_pass++;
    n_checks++; if (bus.s2p_len !== 4'h0) $display("FAIL rst_len: got %h want 0", bus.s2p_len); else n_pass++;
    n_checks++; if (bus.s2p_data_in !== 1'b0) $display("FAIL rst_din: got %b want 0", bus.s2p_data_in); else n_pass++;
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.grant !== '0) $display("FAIL idle_grant: got %b want 0", bus.grant); else n_pass++;
    m_ptr = 0;
  endtask

  task automatic test_rr_all();
    int idx, didx, exp, prev_d; bit to, dto; logic [15:0] d; logic e;
    for (int i = 0; i < NREQ; i++) begin
      tb_word[i] = 16'($urandom); tb_len[i] = 3; bus.req_len[4*i +: 4] = 4'd3;
    end
    bus.req = '1;
    prev_d = -1;
    for (int t = 0; t < 5; t++) begin
      exp = rr_pick('1, m_ptr);
      wait_grant(idx, to);
      n_checks++; if (to || idx != exp) $display("FAIL rr_grant t=%0d: got %0d want %0d", t, idx, exp); else n_pass++;
      if (t > 0) begin
        n_checks++; if (g_cyc - prev_d != 2) $display("FAIL rr_gap t=%0d: got %0d want 2", t, g_cyc - prev_d); else n_pass++;
      end
      wait_done(didx, d, e, dto);
      n_checks++; if (dto || didx != exp) $display("FAIL rr_done t=%0d: got %0d want %0d", t, didx, exp); else n_pass++;
      n_checks++; if (d !== exp_word(tb_word[exp], 3) || e !== 1'b0)
        $display("FAIL rr_data t=%0d: got %h err %b want %h err 0", t, d, e, exp_word(tb_word[exp], 3)); else n_pass++;
      if (t > 0) begin
        n_checks++; if (d_cyc - prev_d != 5) $display("FAIL rr_spacing t=%0d: got %0d want 5", t, d_cyc - prev_d); else n_pass++;
      end
      prev_d = d_cyc;
      m_ptr = (exp + 1) % NREQ;
    end
    bus.req = '0;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int idx, didx; bit to, dto; logic [15:0] d; logic e;
    tb_word[1] = 16'h000B; tb_len[1] = 4; bus.req_len[7:4] = 4'd4;
    bus.req = 4'b0010;
    wait_grant(idx, to);
    n_checks++; if (to || bus.grant !== 4'b0010) $display("FAIL single_grant: got %b want 0010", bus.grant); else n_pass++;
    n_checks++; if (bus.s2p_len !== 4'd4) $display("FAIL single_len: got %0d want 4", bus.s2p_len); else n_pass++;
    wait_done(didx, d, e, dto);
    n_checks++; if (dto || bus.done !== 4'b0010) $display("FAIL single_done: got %b want 0010", bus.done); else n_pass++;
    n_checks++; if (d !== 16'h000B || e !== 1'b0) $display("FAIL single_data: got %h err %b want 000b err 0", d, e); else n_pass++;
    n_checks++; if (d_cyc - g_cyc != 4) $display("FAIL single_dur: got %0d want 4", d_cyc - g_cyc); else n_pass++;
    bus.req = '0;
    m_ptr = 2;
    tick();
    n_checks++; if (bus.done !== '0) $display("FAIL single_pulse: got %b want 0", bus.done); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_len16();
    int idx, didx; bit to, dto; logic [15:0] d; logic e;
    tb_word[0] = 16'hA5C3; tb_len[0] = 0; bus.req_len[3:0] = 4'd0;
    bus.req = 4'b0001;
    wait_grant(idx, to);
    n_checks++; if (to || idx != 0) $display("FAIL l16_grant: got %0d want 0", idx); else n_pass++;
    wait_done(didx, d, e, dto);
    n_checks++; if (dto || d !== 16'hA5C3 || e !== 1'b0) $display("FAIL l16_data: got %h err %b want a5c3 err 0", d, e); else n_pass++;
    n_checks++; if (en_cnt - en_base != 16) $display("FAIL l16_enable: got %0d want 16", en_cnt - en_base); else n_pass++;
    bus.req = '0;
    m_ptr = 1;
    repeat (3) tick();
  endtask

  task automatic test_random();
    int idx, didx, exp, prev_d; bit to, dto; logic [15:0] d; logic e;
    logic [NREQ-1:0] rem;
    prev_d = -1;
    for (int r = 0; r < 4; r++) begin
      rem = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) if (rem[i]) begin
        tb_word[i] = 16'($urandom); tb_len[i] = $urandom_range(0, 15);
        bus.req_len[4*i +: 4] = 4'(tb_len[i]);
      end
      bus.req = rem;
      while (rem != '0) begin
        exp = rr_pick(rem, m_ptr);
        wait_grant(idx, to);
        n_checks++; if (to || idx != exp) $display("FAIL rnd_grant r=%0d: got %0d want %0d", r, idx, exp); else n_pass++;
        n_checks++; if (bus.s2p_len !== 4'(tb_len[exp])) $display("FAIL rnd_len r=%0d: got %0d want %0d", r, bus.s2p_len, tb_len[exp]); else n_pass++;
        if (prev_d >= 0) begin
          n_checks++; if (g_cyc - prev_d != 2) $display("FAIL rnd_gap r=%0d: got %0d want 2", r, g_cyc - prev_d); else n_pass++;
        end
        bus.req_len[4*exp +: 4] = 4'($urandom);
        wait_done(didx, d, e, dto);
        n_checks++; if (dto || didx != exp || d !== exp_word(tb_word[exp], tb_len[exp]) || e !== 1'b0)
          $display("FAIL rnd_done r=%0d: got idx %0d data %h err %b want idx %0d data %h err 0",
                   r, didx, d, e, exp, exp_word(tb_word[exp], tb_len[exp])); else n_pass++;
        n_checks++; if (d_cyc - g_cyc != ((tb_len[exp] == 0) ? 16 : tb_len[exp]))
          $display("FAIL rnd_dur r=%0d: got %0d want %0d", r, d_cyc - g_cyc, tb_len[exp]); else n_pass++;
        prev_d = d_cyc;
        bus.req[exp] = 1'b0;
        rem[exp] = 1'b0;
        m_ptr = (exp + 1) % NREQ;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int idx, didx, a, b, e1, e2; bit to, dto; logic [15:0] d; logic e;
    logic [NREQ-1:0] m;
    a = $urandom_range(0, NREQ - 1);
    b = (a + 1 + $urandom_range(0, NREQ - 2)) % NREQ;
    m = '0; m[a] = 1'b1; m[b] = 1'b1;
    for (int i = 0; i < NREQ; i++) if (m[i]) begin
      tb_word[i] = 16'($urandom); tb_len[i] = 5; bus.req_len[4*i +: 4] = 4'd5;
    end
    stub_low = 1'b1;
    bus.req = m;
    e1 = rr_pick(m, m_ptr);
    wait_grant(idx, to);
    n_checks++; if (to || idx != e1) $display("FAIL tmo_grant: got %0d want %0d", idx, e1); else n_pass++;
    wait_done(didx, d, e, dto);
    n_checks++; if (dto || didx != e1 || e !== 1'b1 || d !== 16'h0)
      $display("FAIL tmo_done: got idx %0d err %b data %h want idx %0d err 1 data 0000", didx, e, d, e1); else n_pass++;
    n_checks++; if (d_cyc - g_cyc != 5 + TO_SLACK) $display("FAIL tmo_dur: got %0d want %0d", d_cyc - g_cyc, 5 + TO_SLACK); else n_pass++;
    n_checks++; if (en_cnt - en_base != 5 + TO_SLACK) $display("FAIL tmo_enable: got %0d want %0d", en_cnt - en_base, 5 + TO_SLACK); else n_pass++;
    stub_low = 1'b0;
    bus.req[e1] = 1'b0;
    m[e1] = 1'b0;
    m_ptr = (e1 + 1) % NREQ;
    tick();
    n_checks++; if (bus.err !== 1'b0) $display("FAIL tmo_err_pulse: got %b want 0", bus.err); else n_pass++;
    e2 = rr_pick(m, m_ptr);
    wait_grant(idx, to);
    n_checks++; if (to || idx != e2 || g_cyc - d_cyc != 2)
      $display("FAIL tmo_next: got idx %0d gap %0d want idx %0d gap 2", idx, g_cyc - d_cyc, e2); else n_pass++;
    wait_done(didx, d, e, dto);
    n_checks++; if (dto || d !== exp_word(tb_word[e2], 5) || e !== 1'b0)
      $display("FAIL tmo_next_data: got %h err %b want %h err 0", d, e, exp_word(tb_word[e2], 5)); else n_pass++;
    bus.req = '0;
    m_ptr = (e2 + 1) % NREQ;
    repeat (3) tick();
  endtask

  task automatic test_req_drop();
    int idx, didx, l, seen; bit to, dto; logic [15:0] d; logic e;
    l = $urandom_range(3, 15);
    tb_word[2] = 16'($urandom); tb_len[2] = l; bus.req_len[11:8] = 4'(l);
    bus.req = 4'b0100;
    wait_grant(idx, to);
    n_checks++; if (to || idx != 2) $display("FAIL drop_grant: got %0d want 2", idx); else n_pass++;
    tick();
    bus.req[2] = 1'b0;
    wait_done(didx, d, e, dto);
    n_checks++; if (dto || didx != 2 || d !== exp_word(tb_word[2], l))
      $display("FAIL drop_done: got idx %0d data %h want idx 2 data %h", didx, d, exp_word(tb_word[2], l)); else n_pass++;
    n_checks++; if (d_cyc - g_cyc != l) $display("FAIL drop_dur: got %0d want %0d", d_cyc - g_cyc, l); else n_pass++;
    m_ptr = 3;
    seen = 0;
    repeat (5) begin tick(); if (bus.grant !== '0 || bus.s2p_enable !== 1'b0) seen++; end
    n_checks++; if (seen != 0) $display("FAIL drop_idle: got %0d busy cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int idx, didx, e1, e2; bit to, dto; logic [15:0] d; logic e;
    for (int i = 1; i < NREQ; i += 2) begin
      tb_word[i] = 16'($urandom); tb_len[i] = 8; bus.req_len[4*i +: 4] = 4'd8;
    end
    bus.req = 4'b1010;
    e1 = rr_pick(4'b1010, m_ptr);
    wait_grant(idx, to);
    n_checks++; if (to || idx != e1) $display("FAIL rmid_grant: got %0d want %0d", idx, e1); else n_pass++;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.grant !== '0 || bus.s2p_enable !== 1'b0 || bus.done !== '0)
      $display("FAIL rmid_async: got grant %b en %b done %b want 0 0 0", bus.grant, bus.s2p_enable, bus.done); else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
    m_ptr = 0;
    e2 = rr_pick(4'b1010, m_ptr);
    wait_grant(idx, to);
    n_checks++; if (to || idx != e2) $display("FAIL rmid_regrant: got %0d want %0d", idx, e2); else n_pass++;
    wait_done(didx, d, e, dto);
    n_checks++; if (dto || didx != e2 || d !== exp_word(tb_word[e2], 8) || e !== 1'b0)
      $display("FAIL rmid_data: got idx %0d data %h err %b want idx %0d data %h err 0", didx, d, e, e2, exp_word(tb_word[e2], 8)); else n_pass++;
    bus.req = '0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_single();
    test_len16();
    test_random();
    test_timeout();
    test_req_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
